data_cache: RTL
===============

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (load/store port) and the data memory port. Hits are served combinationally in the same cycle with no stall. On a miss the pipeline is stalled while a dirty victim line is written back and the missing 4-word line is filled from memory one word per handshake. The block also keeps hit and miss counters for performance reporting.

## Interface
- `WORD_SIZE`, 16, data and address width
- `NUM_LINES`, 4, number of cache lines; index width is log2(`NUM_LINES`)
- Line size is fixed at 4 words.
- Address split: `[1:0]` word offset, `[3:2]` index, `[15:4]` tag (for `NUM_LINES`=4).

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_read`  in  1  load request from MEM stage
- `cpu_write`  in  1  store request from MEM stage
- `cpu_addr`  in  16  word address
- `cpu_wdata`  in  16  store data
- `cpu_rdata`  out  16  load data; valid when `cpu_stall`=0 and `cpu_read`=1
- `cpu_stall`  out  1  high while the current request cannot complete this cycle
- `mem_read`  out  1  memory word read request
- `mem_write`  out  1  memory word write request
- `mem_addr`  out  16  memory word address
- `mem_wdata`  out  16  write-back data
- `mem_rdata`  in  16  fill data; valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the current word transfer at this posedge
- `num_hit`  out  16  count of accesses that hit on first lookup
- `num_miss`  out  16  count of accesses that missed

## Operation
- **Per-line storage:** `valid`, `dirty`, tag, and 4 data words.
- **Hit definition:** `hit = valid[idx] & (tag[idx] == cpu_addr tag)`.
- **Request handling:**
  - Request = `cpu_read | cpu_write`.
  - If both are high, the request is treated as a write.
  - `cpu_stall = request & ~(state==IDLE & hit)`, combinational.
  - `cpu_rdata` = `data[idx][off]`, combinational. It is 0 when there is no read.
- **Write hit in IDLE:** at posedge, `data[idx][off] <= cpu_wdata` and `dirty[idx] <= 1`.
- **FSM states:** IDLE, WBACK, FILL. A 2-bit word counter `cnt` is shared by WBACK and FILL.
- **IDLE:**
  - On request & ~hit, `num_miss` increments.
  - If `valid & dirty`, go to WBACK with `cnt` = 0; otherwise go to FILL with `cnt` = 0.
- **WBACK:**
  - `mem_write` = 1, `mem_addr = {old_tag, idx, cnt}`, `mem_wdata = data[idx][cnt]`.
  - On `mem_ready`, `cnt` increments.
  - On `mem_ready` with `cnt` = 3: `dirty[idx] <= 0`, go to FILL with `cnt` = 0.
- **FILL:**
  - `mem_read` = 1, `mem_addr = {new_tag, idx, cnt}`.
  - On `mem_ready`, `data[idx][cnt] <= mem_rdata` and `cnt` increments.
  - On `mem_ready` with `cnt` = 3: `tag <= new_tag`, `valid <= 1`, `dirty <= 0`, set `replay` flag, go to IDLE.
- **Replay:** the held request now hits in IDLE, stall drops, and a write updates the line and sets dirty.
- **`num_hit`:** increments in IDLE on request & hit & ~`replay`. `replay` clears on the next posedge.
- **Counters:** 16-bit, wrap at 0xFFFF to 0.
- **Memory outputs:** `mem_read`/`mem_write` are never both 1. Both are 0 in IDLE; `mem_addr` and `mem_wdata` are 0 in IDLE.
- **Request stability:** `cpu_addr`/`cpu_wdata`/`cpu_read`/`cpu_write` must be held stable by the pipeline while `cpu_stall`=1. The miss tag and index are taken from `cpu_addr` during WBACK/FILL.

## Timing
- **Reset (async, `reset_n`=0):** state IDLE, `cnt` 0, all `valid`/`dirty` 0, `replay` 0, `num_hit`/`num_miss` 0, `mem_read`/`mem_write` 0, `mem_addr`/`mem_wdata` 0. Data array contents are don't-care.
- **Reset mid-miss:** the transfer is aborted immediately, memory requests drop the same instant, and no line becomes valid.
- **Hit latency:** 0 cycles (same-cycle data, no stall).
- **Clean miss, `mem_ready` tied high:** stall for 5 cycles (1 IDLE detect + 4 FILL), data on the 6th cycle.
- **Dirty miss, `mem_ready` tied high:** stall for 9 cycles (1 + 4 WBACK + 4 FILL).
- **Memory wait states:** each cycle with `mem_ready`=0 adds one stall cycle, and the request and address are held unchanged.
- **Access to the line just filled:** a hit the cycle after replay.

## Test plan
- **Reset then cold read:** read 0x0012, memory words 0x0010-0x0013 = 0xA0..0xA3, `mem_ready`=1 → stall 5 cycles, `mem_addr` 0x0010..0x0013, `cpu_rdata`=0xA2, `num_miss`=1, `num_hit`=0.
- **Hit after fill:** read 0x0013 next → no stall, `cpu_rdata`=0xA3, `num_hit`=1.
- **Write hit then dirty eviction:**
  - Write 0x0011 ← 0x5555 (hit, no stall).
  - Read 0x0051 (same index, different tag) → WBACK `mem_write` at 0x0010..0x0013 with data 0xA0, 0x5555, 0xA2, 0xA3, then FILL at 0x0050..0x0053.
  - Stall 9 cycles, `num_miss`=2.
- **Write miss (allocate):** write 0x0024 ← 0x1234 → fill 0x0024..0x0027, then line dirty; a later read of 0x0024 returns 0x1234 with no stall.
- **Wait states:** `mem_ready` low for 2 cycles on word 1 of a fill → stall extends to 7 cycles, and `mem_addr` is held at word 1 while `mem_ready`=0.
- **Async reset during FILL after 2 words:** `mem_read` drops without a clock edge; after release, a read of the same address misses again and `num_miss` restarts at 1.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and data memory.
// Hits complete combinationally; misses stall the pipeline through write-back and 4-word fill.
module data_cache #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [15:0]          num_hit,
    output logic [15:0]          num_miss,
    output logic [1:0]           fsm_state
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - 2;

    typedef enum logic [1:0] {IDLE = 2'd0, WBACK = 2'd1, FILL = 2'd2} state_t;

    // Memory handshake: mem_read/mem_write act as a valid that stays high with a
    // stable mem_addr/mem_wdata until the posedge where mem_ready=1 completes the word.
    state_t               state_q, state_d;
    logic [1:0]           cnt_q;
    logic                 replay_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q [NUM_LINES][4];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [TAG_W-1:0] req_tag;
    logic             request;
    logic             hit;
    logic             idle_hit;

    assign idx      = cpu_addr[IDX_W+1:2];
    assign off      = cpu_addr[1:0];
    assign req_tag  = cpu_addr[WORD_SIZE-1:IDX_W+2];
    assign request  = cpu_read | cpu_write;
    assign hit      = valid_q[idx] & (tag_q[idx] == req_tag);
    assign idle_hit = (state_q == IDLE) & hit;

    assign cpu_stall = request & ~idle_hit;
    assign cpu_rdata = cpu_read ? data_q[idx][off] : '0;
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (request && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WBACK : FILL;
            end
            WBACK: begin
                if (mem_ready && cnt_q == 2'd3)
                    state_d = FILL;
            end
            FILL: begin
                if (mem_ready && cnt_q == 2'd3)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port is driven purely from state so an async reset drops it at once.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[idx], idx, cnt_q};
                mem_wdata = data_q[idx][cnt_q];
            end
            FILL: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, idx, cnt_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 2'd0;
            replay_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            num_hit  <= 16'd0;
            num_miss <= 16'd0;
            for (int i = 0; i < NUM_LINES; i++)
                tag_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    replay_q <= 1'b0;
                    if (request && hit) begin
                        if (!replay_q)
                            num_hit <= num_hit + 16'd1;
                        if (cpu_write)
                            dirty_q[idx] <= 1'b1;
                    end else if (request) begin
                        num_miss <= num_miss + 16'd1;
                        cnt_q    <= 2'd0;
                    end
                end
                WBACK: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            dirty_q[idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            tag_q[idx]   <= req_tag;
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b0;
                            replay_q     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data array has no reset; valid bits guard its contents.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cpu_write && hit)
            data_q[idx][off] <= cpu_wdata;
        else if (state_q == FILL && mem_ready)
            data_q[idx][cnt_q] <= mem_rdata;
    end
endmodule
